// File: rtl/axis_pkg.sv
// Shared types and helpers for the AXI-Stream master FIFO.
// Both the FIFO top level and its storage array import this package.
package axis_pkg;

    localparam int SOF_BIT = 0;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FULL   = 2'd2
    } axis_fifo_state_t;

    // The level counter needs to hold every value from 0 up to and including depth.
    function automatic int level_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/axis_fifo_mem.sv
// Storage for the AXI-Stream master FIFO: a register array with one synchronous
// write port and one asynchronous read port. The contents are not reset.
module axis_fifo_mem #(
    parameter int DEPTH   = 4,
    parameter int WIDTH   = 34,
    parameter int PTR_W   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axis_master_fifo.sv
// AXI-Stream master with a DEPTH-entry FIFO between the producer and m_axis,
// plus frame and line statistics counted on the beats that leave the FIFO.
module axis_master_fifo
    import axis_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 1,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [DATA_WIDTH-1:0]               data_in,
    input  logic                                valid_in,
    input  logic                                last_in,
    input  logic [USER_WIDTH-1:0]               user_in,
    output logic                                ready_out,
    input  logic                                flush,
    output logic [DATA_WIDTH-1:0]               m_axis_tdata,
    output logic                                m_axis_tvalid,
    input  logic                                m_axis_tready,
    output logic                                m_axis_tlast,
    output logic [USER_WIDTH-1:0]               m_axis_tuser,
    output logic [level_width(DEPTH)-1:0]       level,
    output logic [CNT_WIDTH-1:0]                frame_count,
    output logic [CNT_WIDTH-1:0]                line_count
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LVL_W   = level_width(DEPTH);
    localparam int ENTRY_W = DATA_WIDTH + 1 + USER_WIDTH;

    // Handshakes: a beat moves on a side only in a cycle where both valid and
    // ready are high at the rising edge. ready_out and m_axis_tvalid are decoded
    // from registered state only, so neither depends on the opposite valid/ready.
    axis_fifo_state_t       state, state_nxt;
    logic [PTR_W-1:0]       wr_ptr, rd_ptr;
    logic [LVL_W-1:0]       level_nxt;
    logic                   push, pop;
    logic [ENTRY_W-1:0]     wr_entry, rd_entry;
    logic [DATA_WIDTH-1:0]  head_data;
    logic                   head_last;
    logic [USER_WIDTH-1:0]  head_user;

    assign push     = valid_in && ready_out;
    assign pop      = m_axis_tvalid && m_axis_tready;
    assign wr_entry = {user_in, last_in, data_in};
    assign {head_user, head_last, head_data} = rd_entry;

    axis_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push && !flush),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (rd_entry)
    );

    always_comb begin
        level_nxt = level;
        if (push && !pop) begin
            level_nxt = level + LVL_W'(1);
        end else if (pop && !push) begin
            level_nxt = level - LVL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = ST_EMPTY;
        ready_out     = 1'b0;
        m_axis_tvalid = 1'b0;
        case (state)
            ST_EMPTY:  begin ready_out = 1'b1; m_axis_tvalid = 1'b0; end
            ST_ACTIVE: begin ready_out = 1'b1; m_axis_tvalid = 1'b1; end
            ST_FULL:   begin ready_out = 1'b0; m_axis_tvalid = 1'b1; end
            default:   begin ready_out = 1'b1; m_axis_tvalid = 1'b0; end
        endcase
        if (flush) begin
            state_nxt = ST_EMPTY;
        end else if (level_nxt == '0) begin
            state_nxt = ST_EMPTY;
        end else if (level_nxt == LVL_W'(DEPTH)) begin
            state_nxt = ST_FULL;
        end else begin
            state_nxt = ST_ACTIVE;
        end
    end

    // Flush wins over any same-cycle push or pop: nothing is stored and nothing is counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            frame_count <= '0;
            line_count  <= '0;
        end else if (flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            frame_count <= '0;
            line_count  <= '0;
        end else begin
            level <= level_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                if (head_user[SOF_BIT]) begin
                    frame_count <= frame_count + CNT_WIDTH'(1);
                end
                if (head_last) begin
                    line_count <= line_count + CNT_WIDTH'(1);
                end
            end
        end
    end

    assign m_axis_tdata = m_axis_tvalid ? head_data : '0;
    assign m_axis_tlast = m_axis_tvalid ? head_last : 1'b0;
    assign m_axis_tuser = m_axis_tvalid ? head_user : '0;

endmodule

// File: doc/axis_master_fifo.md
Name: axis_master_fifo

Overview:
- Parametrised AXI-Stream master with an internal FIFO between the pixel/data producer and the downstream AXI-Stream slave.
- Accepts beats from the producer with a valid/ready handshake, stores DEPTH beats (data + tlast + tuser), and presents them on the m_axis port under full backpressure. No beat is ever dropped or duplicated.
- Keeps per-stream statistics: frames started and lines completed.
- Sits at the output of each processing stage, in place of the single-register master.

Parameters:
- DATA_WIDTH, 32, tdata width in bits (>=1).
- USER_WIDTH, 1, tuser width in bits; bit 0 = start of frame (>=1).
- DEPTH, 4, FIFO entries; power of 2, >=2.
- CNT_WIDTH, 16, width of statistics counters.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- data_in  in  DATA_WIDTH  producer data.
- valid_in  in  1  producer beat valid.
- last_in  in  1  producer end-of-line.
- user_in  in  USER_WIDTH  producer user bits; [0] = start of frame.
- ready_out  out  1  FIFO can accept a beat.
- flush  in  1  synchronous clear of FIFO contents and counters.
- m_axis_tdata  out  DATA_WIDTH  AXI-Stream data.
- m_axis_tvalid  out  1  AXI-Stream valid.
- m_axis_tready  in  1  AXI-Stream ready.
- m_axis_tlast  out  1  end of line.
- m_axis_tuser  out  USER_WIDTH  user bits; [0] = start of frame.
- level  out  $clog2(DEPTH+1)  current occupancy.
- frame_count  out  CNT_WIDTH  beats sent with tuser[0]=1.
- line_count  out  CNT_WIDTH  beats sent with tlast=1.

Behaviour:
- Reset (rst_n low, asynchronous): pointers, level, frame_count and line_count go to 0. Outputs after reset: ready_out=1, m_axis_tvalid=0, tdata/tlast/tuser=0. Storage contents need not be reset.
- Push = valid_in && ready_out. Pop = m_axis_tvalid && m_axis_tready.
- ready_out = (level != DEPTH). It is combinational from registered state only and never depends on valid_in.
- m_axis_tvalid = (level != 0).
- tdata/tlast/tuser are driven from the head entry when tvalid=1, and forced to 0 when tvalid=0.
- Latency: a beat pushed at edge N is visible on m_axis at cycle N+1. There is no combinational pass-through from the producer to m_axis.
- Throughput: one beat per cycle sustained when m_axis_tready stays high.
- Pointers: rd_ptr and wr_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH naturally. level is tracked separately.
- level update per cycle:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged
  - neither: unchanged
- Full (level=DEPTH): ready_out=0. A pop in the same cycle does not allow a push that cycle; ready_out returns to 1 the cycle after the pop.
- Empty (level=0): no pop is possible. A push makes tvalid=1 at the next cycle.
- AXI stability: once m_axis_tvalid=1, tdata/tlast/tuser/tvalid hold stable until a pop. Flush is the only exception.
- Counters:
  - Increment on pop only: frame_count when tuser[0]=1, line_count when tlast=1. Both increment if both bits are set.
  - Counters wrap at 2^CNT_WIDTH.
- Flush:
  - Clears pointers, level and counters at the next edge.
  - Takes priority over a simultaneous push or pop; that push is discarded and that pop is not counted.
  - tvalid may drop without a handshake.
- Internal state machine (typedef axis_fifo_state_t):
  - EMPTY: level=0.
  - ACTIVE: 0<level<DEPTH.
  - FULL: level=DEPTH.
  - Next state derives from next level.
  - Flush forces EMPTY.
  - Default branch goes to EMPTY.
  - ready_out and tvalid decode from this state.
- Reset asserted mid-burst: in-flight beats are lost and outputs take their reset values immediately. After release, the first accepted beat is the first beat out.

Decomposition:
- Shared package axis_pkg holds:
  - axis_fifo_state_t.
  - A function for the level width.
  - Constant SOF_BIT = 0.
- One sub-module, axis_fifo_mem: a DEPTH x (DATA_WIDTH+1+USER_WIDTH) register array.
  - One synchronous write port.
  - One asynchronous read port at rd_ptr.
  - No reset.
- The top level holds the pointers, level, state, counters and output gating.

Test Plan:
- Reset then idle: all outputs 0 except ready_out=1, level=0; m_axis_tvalid stays 0 for 10 cycles.
- DEPTH=4, tready=1, push 0x11,0x22,0x33 on consecutive cycles -> same values on tdata at cycles +1..+3; level never exceeds 1.
- tready=0, push 5 beats 0xA0..0xA4 -> level=4 and ready_out=0 after the 4th push; the 5th beat is held by the producer. Raise tready -> out 0xA0..0xA4 in order, no gaps once 0xA4 is accepted.
- Frame of 2 lines x 3 beats (tuser[0] on beat 0, tlast on beats 2 and 5), random tready -> frame_count=1, line_count=2; tvalid/tdata stable during every tready=0 stall.
- Level=3, flush with simultaneous push and pop -> next cycle level=0, tvalid=0, counters=0; the pushed beat never appears.
- rst_n pulsed low mid-burst at level=2 -> outputs at reset values within the same cycle; after release, the next pushed beat 0x5A appears as the first output.
